seq_div32_16: RTL and testbench



---
 rtl/seq_div_pkg.sv | 13 +
 rtl/seq_div32_16_div_step.sv | 22 ++
 rtl/seq_div32_16.sv | 149 ++++++++++++++
 tb/tb_seq_div32_16.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared widths and state encoding for the 32/16 sequential divider
package seq_div_pkg;

    localparam int DW = 16;
    localparam int QW = 2 * DW;
    localparam int CW = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/seq_div32_16_div_step.sv
// rtl/seq_div32_16_div_step.sv - one combinational restoring-division step
module div_step
    import seq_div_pkg::*;
(
    input  logic [DW-1:0] rem,
    input  logic          in_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_next,
    output logic          q_bit
);

    logic [DW:0] pr;

    // Shift the next dividend bit into the partial remainder and subtract when it fits.
    // The running remainder is always below the divisor, so the difference fits in DW bits.
    always_comb begin
        pr       = {rem, in_bit};
        q_bit    = (pr >= {1'b0, divisor});
        rem_next = q_bit ? DW'(pr - {1'b0, divisor}) : pr[DW-1:0];
    end

endmodule

// File: rtl/seq_div32_16.sv
// rtl/seq_div32_16.sv - sequential unsigned 32/16 restoring divider; optional DIV_ZERO_CHK_EN
module seq_div32_16
    import seq_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [QW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] dq_q, dq_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [QW-1:0] quot_q, quot_d;
    logic [DW-1:0] remo_q, remo_d;
`ifdef DIV_ZERO_CHK_EN
    logic          dz_q, dz_d;
    logic          dbz_q, dbz_d;
`endif

    logic [DW-1:0] step_rem;
    logic          step_q;

    div_step u_step (
        .rem      (rem_q),
        .in_bit   (dq_q[QW-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Handshake FSM: accept in IDLE, one quotient bit per RUN cycle, publish on the last step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remo_d  = remo_q;
`ifdef DIV_ZERO_CHK_EN
        dz_d    = dz_q;
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dq_d    = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef DIV_ZERO_CHK_EN
                    dz_d    = (divisor == '0);
`endif
                end
            end
            RUN: begin
`ifdef DIV_ZERO_CHK_EN
                if (dz_q) begin
                    // Short-circuit: same values the full iteration would produce for a zero divisor.
                    quot_d  = '1;
                    remo_d  = dq_q[DW-1:0];
                    dbz_d   = 1'b1;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else
`endif
                begin
                    dq_d  = {dq_q[QW-2:0], step_q};
                    rem_d = step_rem;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(QW - 1)) begin
                        quot_d  = {dq_q[QW-2:0], step_q};
                        remo_d  = step_rem;
`ifdef DIV_ZERO_CHK_EN
                        dbz_d   = 1'b0;
`endif
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything at once, aborting any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
`ifdef DIV_ZERO_CHK_EN
            dz_q    <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
`ifdef DIV_ZERO_CHK_EN
            dz_q    <= dz_d;
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
`ifdef DIV_ZERO_CHK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div32_16.sv
// tb/tb_seq_div32_16.sv - scoreboard bench for seq_div32_16 against an arithmetic reference
module tb_seq_div32_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    seq_div32_16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

`ifdef DIV_ZERO_CHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    // Reference: plain integer division; a zero divisor yields all-ones and the low dividend half.
    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b, input int c0);
        exp_t m;
        if (b == 16'd0) begin
            m.q   = 32'hFFFF_FFFF;
            m.r   = a[15:0];
            m.dbz = ZCHK;
            m.cyc = c0 + (ZCHK ? 1 : 32);
        end else begin
            m.q   = a / {16'd0, b};
            m.r   = 16'(a % {16'd0, b});
            m.dbz = 1'b0;
            m.cyc = c0 + 32;
        end
        return m;
    endfunction

    // Drive one request; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [15:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(a, b, cyc));
        n_vec++;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Directed request with a hand-derived expected result checked against the model entry.
    task automatic issue_x(input logic [31:0] a, input logic [15:0] b,
                           input logic [31:0] q, input logic [15:0] r);
        exp_t e;
        issue(a, b);
        e = sb[$];
        e.q = q;
        e.r = r;
        sb[sb.size()-1] = e;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s: done not seen within 60 cycles", name);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("quotient", quotient, e.q);
                check("remainder", {16'd0, remainder}, {16'd0, e.r});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [15:0] b;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue_x(32'd100, 16'd7, 32'd14, 16'd2);
        wait_done("t100_7");
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        issue_x(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000);
        wait_done("max_max");
        @(negedge clk);
        issue_x(32'h1234_5678, 16'h0001, 32'h1234_5678, 16'h0000);
        wait_done("div_by_one");
        @(negedge clk);

        // Back-to-back: second start is presented during the done cycle.
        issue_x(32'd5, 16'd9, 32'd0, 16'd5);
        wait_done("small_num");
        issue_x(32'h0001_0000, 16'h0100, 32'h0000_0100, 16'h0000);
        wait_done("back_to_back");
        @(negedge clk);

        // Start pulses while busy must not disturb the running operation.
        issue(32'h0000_1000, 16'h0010);
        repeat (3) @(negedge clk);
        dividend = 32'hDEAD_BEEF; divisor = 16'h0003; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        dividend = 32'h0000_0001; divisor = 16'h0005; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start");
        repeat (3) @(negedge clk);

        issue_x(32'hABCD_1234, 16'h0000, 32'hFFFF_FFFF, 16'h1234);
        wait_done("div_zero");
        @(negedge clk);

        // Asynchronous reset part-way through a run aborts it without a done pulse.
        issue(32'd100, 16'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        issue_x(32'd100, 16'd7, 32'd14, 16'd2);
        wait_done("after_abort");
        @(negedge clk);

        // Random operands: products of two halves, small divisors, zero divisors, full range.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] x;
            case ($urandom_range(0, 4))
                0: begin
                    x = 16'($urandom);
                    b = 16'($urandom);
                    a = {16'd0, x} * {16'd0, b};
                end
                1: begin
                    a = $urandom;
                    b = 16'($urandom_range(1, 15));
                end
                2: begin
                    a = $urandom;
                    b = 16'd0;
                end
                default: begin
                    a = $urandom;
                    b = 16'($urandom);
                end
            endcase
            issue(a, b);
            wait_done("random");
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
